vend_fsm_param: RTL and testbench
=================================

// Module: vend_fsm_param
// PURPOSE
//  Parametrised coin-accumulating vending controller; successor to the fixed nickel/dime 15-cent FSM.
//  Sums nickel/dime/quarter pulses into a credit register and pulses vend when credit >= PRICE.
//  Supports cancel/refund and a busy flag; sits between the coin-acceptor front end and the dispenser.
// PARAMETERS
//  PRICE     15  item price in cents, 1..255
//  NICKEL_V   5  value of N pulse in cents
//  DIME_V    10  value of D pulse in cents
//  QUARTER_V 25  value of Q pulse in cents
//  localparam CREDIT_W = $clog2(PRICE + NICKEL_V + DIME_V + QUARTER_V + 1); all credit/change arithmetic unsigned at CREDIT_W
// PORTS
//  clk         in   1         system clock, rising edge
//  reset       in   1         asynchronous, active-low reset
//  N           in   1         nickel inserted, 1-cycle pulse
//  D           in   1         dime inserted, 1-cycle pulse
//  Q           in   1         quarter inserted, 1-cycle pulse
//  cancel      in   1         refund request, 1-cycle pulse
//  out_value   out  1         vend pulse, 1 cycle per item
//  change      out  CREDIT_W  cents returned; valid when change_vld=1, else 0
//  change_vld  out  1         change/refund pulse, 1 cycle
//  credit      out  CREDIT_W  current registered credit
//  busy        out  1         1 in VEND/REFUND; coins ignored that cycle
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, credit=0, out_value=0, change=0, change_vld=0, busy=0.
//  All outputs registered; response appears the cycle after the sampling edge.
//  sum = N*NICKEL_V + D*DIME_V + Q*QUARTER_V; simultaneous coins all count. tot = credit + sum.
//  States: IDLE (credit=0), COLLECT (0<credit<PRICE), VEND, REFUND.
//  IDLE/COLLECT, cancel=1: -> REFUND; change=tot, change_vld=1, credit=0 (cancel beats coins; that cycle's coins are refunded).
//    cancel with tot=0: no-op, stay IDLE, no change pulse.
//  IDLE/COLLECT, tot>=PRICE: -> VEND; out_value=1 next cycle; excess = tot-PRICE (see CONFIGURATION).
//  IDLE/COLLECT, 0<tot<PRICE: -> COLLECT, credit=tot; tot=0: stay IDLE.
//  VEND (1 cycle, busy=1): coins and cancel ignored (dropped).
//    Exits: credit>=PRICE -> VEND again (back-to-back out_value); credit>0 -> COLLECT; else IDLE.
//  REFUND (1 cycle, busy=1): inputs ignored; -> IDLE.
//  out_value and change_vld are each high exactly one cycle per event; change=0 whenever change_vld=0.
//  Reset mid-VEND/REFUND: pulse aborts immediately; credit is lost.
//  No overflow: tot < 2^CREDIT_W by construction; elaboration $error if PRICE=0 or PRICE>255.
// CONFIGURATION
//  `define VEND_CHANGE_RETURN_EN:
//    defined: on a vend, excess returned in the same cycle as out_value (change=excess, change_vld=1 if excess>0);
//      credit=0; VEND always exits to IDLE.
//    undefined: excess kept as credit (rollover); change_vld pulses only on REFUND.
//      credit>=PRICE after a vend triggers another VEND.
// STRUCTURE
//  vend_pkg: vend_state_e {IDLE, COLLECT, VEND, REFUND}; default coin value constants.
//  Sub-module vend_coin_sum: combinational N/D/Q -> sum[CREDIT_W-1:0], parametrised by coin values.
//  Top module holds the state register, credit register, output registers.
// TESTING (PRICE=15, defaults)
//  reset=0 for 1 cycle, then 1 -> all outputs 0, state IDLE; reset asserted mid-VEND clears out_value immediately.
//  N, then D (separate cycles) -> credit 5 then 15; out_value=1 one cycle; credit=0; no change pulse.
//  Q alone: EN -> out_value=1, change=10, change_vld=1 same cycle, credit=0; no EN -> out_value=1, credit=10.
//  N+D+Q same cycle, no EN -> tot=40: two consecutive out_value pulses, then credit=10 in COLLECT.
//  D, then cancel -> change=10, change_vld=1, credit=0; cancel again in IDLE -> no pulse.
//  Coin during VEND (busy=1) -> credit unchanged; cancel+N same cycle with credit 10 -> refund change=15.

Source files
------------

// File: rtl/vend_pkg.sv
// Purpose : shared types and default coin values for the parametrised vending
//           controller (vend_fsm_param) and its coin adder (vend_coin_sum).
// Contents: vend_state_e state encoding, default price/coin constants.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      REFUND  = 2'd3
   } vend_state_e;

   localparam int PRICE_DEF   = 15;
   localparam int NICKEL_DEF  = 5;
   localparam int DIME_DEF    = 10;
   localparam int QUARTER_DEF = 25;

endpackage

// File: rtl/vend_coin_sum.sv
// Purpose : combinational value of the coins presented in one cycle.
//           Simultaneous pulses are all counted.
// Ports   : N, D, Q  in   coin pulses (nickel, dime, quarter)
//           sum      out  SUM_W-bit total value in cents
module vend_coin_sum #(
   parameter int NICKEL_V  = 5,
   parameter int DIME_V    = 10,
   parameter int QUARTER_V = 25,
   parameter int SUM_W     = 6
) (
   input  logic             N,
   input  logic             D,
   input  logic             Q,
   output logic [SUM_W-1:0] sum
);

   localparam logic [SUM_W-1:0] NV = SUM_W'(NICKEL_V);
   localparam logic [SUM_W-1:0] DV = SUM_W'(DIME_V);
   localparam logic [SUM_W-1:0] QV = SUM_W'(QUARTER_V);

   always_comb begin
      sum = (N ? NV : '0) + (D ? DV : '0) + (Q ? QV : '0);
   end

endmodule

// File: rtl/vend_fsm_param.sv
// Purpose : coin-accumulating vending controller. Sums coin pulses into a
//           credit register and pulses out_value whenever credit reaches PRICE;
//           cancel refunds all credit (including coins in the cancel cycle).
// Ports   : clk         in   system clock, rising edge
//           reset       in   asynchronous active-low reset
//           N, D, Q     in   coin pulses
//           cancel      in   refund request pulse
//           out_value   out  vend pulse, one cycle per item
//           change      out  returned cents, zero unless change_vld
//           change_vld  out  change/refund pulse
//           credit      out  registered credit
//           busy        out  high in VEND/REFUND; inputs dropped that cycle
// Config  : VEND_CHANGE_RETURN_EN defined -> excess returned with the vend
//           pulse and credit cleared; undefined -> excess kept as credit.
//
//  state   | meaning
//  IDLE    | no credit held
//  COLLECT | 0 < credit < PRICE, accepting coins
//  VEND    | one-cycle vend pulse, inputs ignored
//  REFUND  | one-cycle refund pulse, inputs ignored
module vend_fsm_param
   import vend_pkg::*;
#(
   parameter  int PRICE     = PRICE_DEF,
   parameter  int NICKEL_V  = NICKEL_DEF,
   parameter  int DIME_V    = DIME_DEF,
   parameter  int QUARTER_V = QUARTER_DEF,
   localparam int CREDIT_W  = $clog2(PRICE + NICKEL_V + DIME_V + QUARTER_V + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                N,
   input  logic                D,
   input  logic                Q,
   input  logic                cancel,
   output logic                out_value,
   output logic [CREDIT_W-1:0] change,
   output logic                change_vld,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   if (PRICE < 1 || PRICE > 255) begin : g_price_chk
      $error("vend_fsm_param: PRICE must be in 1..255");
   end

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

   vend_state_e         r_state, w_state_nxt;
   logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
   logic [CREDIT_W-1:0] r_change, w_change_nxt;
   logic                r_out_value, w_out_nxt;
   logic                r_change_vld, w_vld_nxt;
   logic                r_busy, w_busy_nxt;
   logic [CREDIT_W-1:0] w_sum;
   logic [CREDIT_W-1:0] w_tot;
`ifdef VEND_CHANGE_RETURN_EN
   logic [CREDIT_W-1:0] w_excess;
`endif

   vend_coin_sum #(
      .NICKEL_V  (NICKEL_V),
      .DIME_V    (DIME_V),
      .QUARTER_V (QUARTER_V),
      .SUM_W     (CREDIT_W)
   ) u_coin_sum (
      .N   (N),
      .D   (D),
      .Q   (Q),
      .sum (w_sum)
   );

   // Credit is always below PRICE while collecting, so tot cannot overflow.
   assign w_tot = r_credit + w_sum;
`ifdef VEND_CHANGE_RETURN_EN
   assign w_excess = w_tot - PRICE_C;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_credit     <= '0;
         r_change     <= '0;
         r_out_value  <= 1'b0;
         r_change_vld <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_credit     <= w_credit_nxt;
         r_change     <= w_change_nxt;
         r_out_value  <= w_out_nxt;
         r_change_vld <= w_vld_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_change_nxt = '0;
      w_out_nxt    = 1'b0;
      w_vld_nxt    = 1'b0;
      w_busy_nxt   = 1'b0;
      case (r_state)
         IDLE, COLLECT: begin
            // Cancel wins over coins; the coins of that cycle go back too.
            if (cancel && (w_tot != '0)) begin
               w_state_nxt  = REFUND;
               w_change_nxt = w_tot;
               w_vld_nxt    = 1'b1;
               w_credit_nxt = '0;
               w_busy_nxt   = 1'b1;
            end else if (w_tot >= PRICE_C) begin
               w_state_nxt = VEND;
               w_out_nxt   = 1'b1;
               w_busy_nxt  = 1'b1;
`ifdef VEND_CHANGE_RETURN_EN
               w_credit_nxt = '0;
               w_change_nxt = w_excess;
               w_vld_nxt    = (w_excess != '0);
`else
               w_credit_nxt = w_tot - PRICE_C;
`endif
            end else if (w_tot != '0) begin
               w_state_nxt  = COLLECT;
               w_credit_nxt = w_tot;
            end else begin
               w_state_nxt  = IDLE;
               w_credit_nxt = '0;
            end
         end
         VEND: begin
`ifdef VEND_CHANGE_RETURN_EN
            w_state_nxt  = IDLE;
            w_credit_nxt = '0;
`else
            // Rolled-over credit may still cover another item.
            if (r_credit >= PRICE_C) begin
               w_state_nxt  = VEND;
               w_credit_nxt = r_credit - PRICE_C;
               w_out_nxt    = 1'b1;
               w_busy_nxt   = 1'b1;
            end else if (r_credit != '0) begin
               w_state_nxt = COLLECT;
            end else begin
               w_state_nxt = IDLE;
            end
`endif
         end
         REFUND: begin
            w_state_nxt  = IDLE;
            w_credit_nxt = '0;
         end
         default: begin
            w_state_nxt  = IDLE;
            w_credit_nxt = '0;
         end
      endcase
   end

   assign out_value  = r_out_value;
   assign change     = r_change;
   assign change_vld = r_change_vld;
   assign credit     = r_credit;
   assign busy       = r_busy;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Bench for vend_fsm_param at PRICE=15 with default coin values. Directed
// scenarios followed by random coin/cancel traffic, all checked cycle by
// cycle against a transaction-level model: each accepted transaction expands
// into a list of expected output cycles (tot/PRICE vend pulses, or a refund).
module tb_vend_fsm_param;

   localparam int PRICE = 15;
   localparam int NV    = 5;
   localparam int DV    = 10;
   localparam int QV    = 25;
   localparam int CW    = $clog2(PRICE + NV + DV + QV + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          N = 1'b0;
   logic          D = 1'b0;
   logic          Q = 1'b0;
   logic          cancel = 1'b0;
   logic          out_value;
   logic [CW-1:0] change;
   logic          change_vld;
   logic [CW-1:0] credit;
   logic          busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int credit;
      bit vout;
      int chg;
      bit vld;
      bit busy;
   } rec_t;

   rec_t cur;
   rec_t pend[$];

   always #5 clk = ~clk;

   vend_fsm_param #(
      .PRICE     (PRICE),
      .NICKEL_V  (NV),
      .DIME_V    (DV),
      .QUARTER_V (QV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .N          (N),
      .D          (D),
      .Q          (Q),
      .cancel     (cancel),
      .out_value  (out_value),
      .change     (change),
      .change_vld (change_vld),
      .credit     (credit),
      .busy       (busy)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".credit"},     int'(credit),     cur.credit);
      chk({tag, ".out_value"},  int'(out_value),  int'(cur.vout));
      chk({tag, ".change"},     int'(change),     cur.chg);
      chk({tag, ".change_vld"}, int'(change_vld), int'(cur.vld));
      chk({tag, ".busy"},       int'(busy),       int'(cur.busy));
   endtask

   task automatic model_reset();
      pend.delete();
      cur = '{credit: 0, vout: 1'b0, chg: 0, vld: 1'b0, busy: 1'b0};
   endtask

   // Advance the model by one clock edge with the inputs sampled at that edge.
   task automatic model_step(input bit n, input bit d, input bit q, input bit c);
      int tot;
      if (cur.busy) begin
         if (pend.size() > 0) cur = pend.pop_front();
         else cur = '{credit: cur.credit, vout: 1'b0, chg: 0, vld: 1'b0, busy: 1'b0};
      end else begin
         tot = cur.credit + int'(n) * NV + int'(d) * DV + int'(q) * QV;
         if (c && tot > 0) begin
            cur = '{credit: 0, vout: 1'b0, chg: tot, vld: 1'b1, busy: 1'b1};
         end else if (tot >= PRICE) begin
`ifdef VEND_CHANGE_RETURN_EN
            cur = '{credit: 0, vout: 1'b1, chg: tot - PRICE, vld: (tot > PRICE), busy: 1'b1};
`else
            for (int k = 1; k <= tot / PRICE; k++)
               pend.push_back('{credit: tot - k * PRICE, vout: 1'b1, chg: 0, vld: 1'b0, busy: 1'b1});
            cur = pend.pop_front();
`endif
         end else begin
            cur = '{credit: tot, vout: 1'b0, chg: 0, vld: 1'b0, busy: 1'b0};
         end
      end
   endtask

   task automatic cycle(input bit n, input bit d, input bit q, input bit c, input string tag);
      N = n; D = d; Q = q; cancel = c;
      @(posedge clk);
      model_step(n, d, q, c);
      #1;
      N = 1'b0; D = 1'b0; Q = 1'b0; cancel = 1'b0;
      check_all(tag);
   endtask

   initial begin
      bit rn, rd, rq, rc;
      model_reset();

      // reset held low across an edge
      @(posedge clk);
      #1;
      check_all("reset");
      chk("reset.credit_zero", int'(credit), 0);
      @(negedge clk);
      reset = 1'b1;

      // N then D reaches exactly PRICE
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "nick");
      chk("nick.credit5", int'(credit), 5);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, "dime_vend");
      chk("dime_vend.out", int'(out_value), 1);
      chk("dime_vend.novld", int'(change_vld), 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "after_vend");

      // quarter alone
      cycle(1'b0, 1'b0, 1'b1, 1'b0, "quarter");
`ifdef VEND_CHANGE_RETURN_EN
      chk("quarter.change10", int'(change), 10);
      chk("quarter.credit0", int'(credit), 0);
`else
      chk("quarter.credit10", int'(credit), 10);
`endif
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "quarter_exit");
      cycle(1'b0, 1'b0, 1'b0, 1'b1, "clear1");
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "clear1_idle");

      // all three coins at once: tot=40
      cycle(1'b1, 1'b1, 1'b1, 1'b0, "ndq");
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "ndq2");
`ifndef VEND_CHANGE_RETURN_EN
      chk("ndq2.second_vend", int'(out_value), 1);
`endif
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "ndq3");
`ifndef VEND_CHANGE_RETURN_EN
      chk("ndq3.credit10", int'(credit), 10);
`endif
      cycle(1'b0, 1'b0, 1'b0, 1'b1, "clear2");
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "clear2_idle");

      // dime then cancel, then cancel with nothing held
      cycle(1'b0, 1'b1, 1'b0, 1'b0, "dime");
      cycle(1'b0, 1'b0, 1'b0, 1'b1, "cancel");
      chk("cancel.change10", int'(change), 10);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "cancel_busy");
      cycle(1'b0, 1'b0, 1'b0, 1'b1, "cancel_empty");
      chk("cancel_empty.novld", int'(change_vld), 0);

      // coin dropped while busy, then cancel+N refunds the coin too
      cycle(1'b0, 1'b0, 1'b1, 1'b0, "q_busy");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "coin_in_vend");
      cycle(1'b1, 1'b0, 1'b0, 1'b1, "cancel_n");
`ifndef VEND_CHANGE_RETURN_EN
      chk("cancel_n.change15", int'(change), 15);
`endif
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "cancel_n_busy");

      // asynchronous reset during a vend pulse
      cycle(1'b0, 1'b0, 1'b1, 1'b0, "pre_rst");
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("mid_rst.out_value", int'(out_value), 0);
      chk("mid_rst.credit", int'(credit), 0);
      chk("mid_rst.busy", int'(busy), 0);
      @(negedge clk);
      reset = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rn = ($urandom % 4) == 0;
         rd = ($urandom % 4) == 0;
         rq = ($urandom % 5) == 0;
         rc = ($urandom % 10) == 0;
         cycle(rn, rd, rq, rc, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
